// File: rtl/cpu_pkg.sv
// Shared definitions for the Simple RISC Machine control path: opcode and
// condition encodings, memory command codes and the fetch sequencer states.
package cpu_pkg;

  // Major opcodes (ir[15:13]) resolved inside the sequencer
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_CALL   = 3'b010;
  localparam logic [2:0] OP_HALT   = 3'b111;

  // Sub-operations (ir[12:11])
  localparam logic [1:0] OPX_COND = 2'b00;  // under OP_BRANCH
  localparam logic [1:0] OPX_BX   = 2'b00;  // under OP_CALL
  localparam logic [1:0] OPX_BLX  = 2'b10;  // under OP_CALL
  localparam logic [1:0] OPX_BL   = 2'b11;  // under OP_CALL

  // Branch condition codes (ir[10:8])
  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  // Memory command encodings
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_DECODE    = 2'b01,
    ST_EXEC_WAIT = 2'b10,
    ST_HALT      = 2'b11
  } seq_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; shared with future predicated
// execution, so it knows nothing about the sequencer.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       taken
);

  // Map the condition code and status flags to a taken decision
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_B:   taken = 1'b1;
      COND_BEQ: taken = z;
      COND_BNE: taken = ~z;
      COND_BLT: taken = n ^ v;
      COND_BLE: taken = (n ^ v) | z;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and program-flow sequencer: owns PC and IR, fetches over
// a ready handshake with timeout, resolves branches/calls/returns locally and
// hands every other instruction to the datapath via exec_start/exec_done.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 9,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
)(
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   mem_addr,
  output logic [1:0]        mem_cmd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        rd_sel,
  input  logic [DATA_W-1:0] reg_value,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              link_we,
  output logic [DATA_W-1:0] link_data,
  output logic              halted,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  seq_state_e        state_r, state_next_s;
  logic [PC_W-1:0]   pc_r, pc_next_s, pc_inc_s, target_s;
  logic [DATA_W-1:0] ir_r, ir_next_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_next_s, wait_cnt_inc_s;
  logic              fetch_err_r, fetch_err_next_s;
  logic [2:0]        opcode_s, cond_s;
  logic [1:0]        op_s;
  logic              taken_s;
  logic              is_cond_s, is_bl_s, is_bx_s, is_blx_s, is_halt_s, is_exec_s;
  logic              unused_s;

  assign opcode_s = ir_r[15:13];
  assign op_s     = ir_r[12:11];
  assign cond_s   = ir_r[10:8];

  assign pc_inc_s       = pc_r + PC_W'(1'b1);
  // 8-bit signed offset is sign-extended by the sized cast; sum wraps mod 2^PC_W
  assign target_s       = pc_inc_s + PC_W'($signed(ir_r[7:0]));
  assign wait_cnt_inc_s = wait_cnt_r + CNT_W'(1'b1);

  assign is_cond_s = (opcode_s == OP_BRANCH) && (op_s == OPX_COND);
  assign is_bl_s   = (opcode_s == OP_CALL) && (op_s == OPX_BL);
  assign is_bx_s   = (opcode_s == OP_CALL) && (op_s == OPX_BX);
  assign is_blx_s  = (opcode_s == OP_CALL) && (op_s == OPX_BLX);
  assign is_halt_s = (opcode_s == OP_HALT);
  assign is_exec_s = ~(is_cond_s | is_bl_s | is_bx_s | is_blx_s | is_halt_s);

  // Register targets only use the low PC bits of the register value
  assign unused_s = ^reg_value[DATA_W-1:PC_W];

  branch_cond_eval u_cond (
    .cond  (cond_s),
    .n     (N),
    .v     (V),
    .z     (Z),
    .taken (taken_s)
  );

  // Next-state, PC, IR, wait-counter and error-flag logic
  always_comb begin
    state_next_s     = state_r;
    pc_next_s        = pc_r;
    ir_next_s        = ir_r;
    wait_cnt_next_s  = wait_cnt_r;
    fetch_err_next_s = fetch_err_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_next_s       = mem_rdata;
          wait_cnt_next_s = {CNT_W{1'b0}};
          state_next_s    = ST_DECODE;
        end else if (wait_cnt_inc_s == TIMEOUT_CNT) begin
          wait_cnt_next_s  = wait_cnt_inc_s;
          fetch_err_next_s = 1'b1;
          state_next_s     = ST_HALT;
        end else begin
          wait_cnt_next_s = wait_cnt_inc_s;
        end
      end
      ST_DECODE: begin
        if (is_cond_s) begin
          pc_next_s    = taken_s ? target_s : pc_inc_s;
          state_next_s = ST_FETCH;
        end else if (is_bl_s) begin
          pc_next_s    = target_s;
          state_next_s = ST_FETCH;
        end else if (is_bx_s || is_blx_s) begin
          pc_next_s    = reg_value[PC_W-1:0];
          state_next_s = ST_FETCH;
        end else if (is_halt_s) begin
          state_next_s = ST_HALT;
        end else begin
          pc_next_s    = pc_inc_s;
          state_next_s = ST_EXEC_WAIT;
        end
      end
      ST_EXEC_WAIT: begin
        if (exec_done) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_EXEC_WAIT;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= PC_W'(RESET_PC);
      ir_r        <= {DATA_W{1'b0}};
      wait_cnt_r  <= {CNT_W{1'b0}};
      fetch_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      ir_r        <= ir_next_s;
      wait_cnt_r  <= wait_cnt_next_s;
      fetch_err_r <= fetch_err_next_s;
    end
  end

  // Moore output decode from the state register and the registered IR
  always_comb begin
    mem_cmd    = MEM_NONE;
    exec_start = 1'b0;
    link_we    = 1'b0;
    halted     = 1'b0;
    case (state_r)
      ST_FETCH:     mem_cmd = MEM_READ;
      ST_DECODE: begin
        exec_start = is_exec_s;
        link_we    = is_bl_s | is_blx_s;
      end
      ST_EXEC_WAIT: mem_cmd = MEM_NONE;
      ST_HALT:      halted = 1'b1;
      default:      mem_cmd = MEM_NONE;
    endcase
  end

  assign mem_addr  = pc_r;
  assign ir        = ir_r;
  assign rd_sel    = ir_r[7:5];
  assign link_data = {{(DATA_W-PC_W){1'b0}}, pc_inc_s};
  assign fetch_err = fetch_err_r;

endmodule
